// File: rtl/tim_arb_pkg.sv
// Shared types and constants for the two-requester APB timer arbiter.
// Optional ACCESS timeout is enabled by defining TIM_ARB_TIMEOUT_EN.
package tim_arb_pkg;

  localparam int NUM_REQ         = 2;
  localparam int TIMEOUT_CYC_DEF = 16;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS,
    RESP
  } state_t;

endpackage

// File: rtl/tim_rr_arb.sv
// Two-way round-robin grant; ptr is the index granted last.
// The grant is only produced while upd is high.
module tim_rr_arb
  import tim_arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] valid,
  input  logic               ptr,
  input  logic               upd,
  output logic [NUM_REQ-1:0] grant
);

  always_comb begin
    grant = '0;
    if (upd) begin
      case (valid)
        2'b11:   grant = ptr ? 2'b01 : 2'b10;
        default: grant = valid;
      endcase
    end
  end

endmodule

// File: rtl/tim_apb_arbiter.sv
// Arbitrates two requesters onto one APB master port toward the timer.
// Define TIM_ARB_TIMEOUT_EN to abort ACCESS after TIMEOUT_CYC cycles.
module tim_apb_arbiter
  import tim_arb_pkg::*;
#(
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF,
  parameter int ADDR_W      = 12
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst,
  input  logic [NUM_REQ-1:0]    req_valid,
  input  logic [NUM_REQ-1:0]    req_write,
  input  logic [2*ADDR_W-1:0]   req_addr,
  input  logic [63:0]           req_wdata,
  input  logic [7:0]            req_strb,
  output logic [NUM_REQ-1:0]    req_ready,
  output logic [NUM_REQ-1:0]    rsp_valid,
  output logic [31:0]           rsp_rdata,
  output logic                  rsp_err,
  output logic                  tim_psel,
  output logic                  tim_penable,
  output logic                  tim_pwrite,
  output logic [ADDR_W-1:0]     tim_paddr,
  output logic [31:0]           tim_pwdata,
  output logic [3:0]            tim_pstrb,
  input  logic [31:0]           tim_prdata,
  input  logic                  tim_pready,
  input  logic                  tim_pslverr
);

  state_t             state;
  logic               last;
  logic [NUM_REQ-1:0] grant;
  logic [NUM_REQ-1:0] owner;
  logic               sel;
  logic               timeout;
  logic               done;

  tim_rr_arb u_arb (
    .valid (req_valid),
    .ptr   (last),
    .upd   (state == IDLE && !sys_rst),
    .grant (grant)
  );

  assign req_ready = grant;
  assign sel       = grant[1];
  assign done      = tim_pready || timeout;

`ifdef TIM_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  logic [CNT_W-1:0] cnt;

  // Held at zero outside ACCESS, so every SETUP starts from a clean count.
  always_ff @(posedge sys_clk) begin
    if (sys_rst || state != ACCESS) cnt <= '0;
    else                            cnt <= cnt + 1'b1;
  end

  assign timeout = (state == ACCESS) && (cnt == CNT_LAST);
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state       <= IDLE;
      last        <= 1'b1;
      owner       <= '0;
      rsp_valid   <= '0;
      rsp_rdata   <= '0;
      rsp_err     <= 1'b0;
      tim_psel    <= 1'b0;
      tim_penable <= 1'b0;
      tim_pwrite  <= 1'b0;
      tim_paddr   <= '0;
      tim_pwdata  <= '0;
      tim_pstrb   <= '0;
    end else begin
      rsp_valid <= '0;
      unique case (state)
        IDLE: if (|grant) begin
          owner      <= grant;
          last       <= sel;
          tim_psel   <= 1'b1;
          tim_pwrite <= req_write[sel];
          tim_paddr  <= sel ? req_addr[2*ADDR_W-1:ADDR_W]
                            : req_addr[ADDR_W-1:0];
          tim_pwdata <= sel ? req_wdata[63:32] : req_wdata[31:0];
          tim_pstrb  <= sel ? req_strb[7:4] : req_strb[3:0];
          state      <= SETUP;
        end
        SETUP: begin
          tim_penable <= 1'b1;
          state       <= ACCESS;
        end
        ACCESS: if (done) begin
          tim_psel    <= 1'b0;
          tim_penable <= 1'b0;
          rsp_valid   <= owner;
          // A timeout reports as an error with no data.
          rsp_err     <= !tim_pready || tim_pslverr;
          rsp_rdata   <= (tim_pready && !tim_pslverr && !tim_pwrite)
                         ? tim_prdata : '0;
          state       <= RESP;
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/tim_apb_arbiter.md
TIM_APB_ARBITER -- requirements
Module: tim_apb_arbiter

Interface
REQ-001 Parameter TIMEOUT_CYC, default 16, SHALL set the max ACCESS-phase cycles before abort (used only with TIM_ARB_TIMEOUT_EN).
REQ-002 Parameter ADDR_W, default 12, SHALL set the APB address width.
REQ-003 sys_clk  input  1  SHALL be the single clock; every flop SHALL sample on its rising edge.
REQ-004 sys_rst  input  1  SHALL be the synchronous, active-high reset.
REQ-005 req_valid  input  2  SHALL be the per-requester transfer request, bit i for requester i.
REQ-006 req_write  input  2  SHALL be the per-requester direction, 1 = write.
REQ-007 req_addr  input  2xADDR_W  SHALL carry the packed byte addresses; requester i SHALL use slice i.
REQ-008 req_wdata  input  2x32  SHALL carry the packed write data.
REQ-009 req_strb  input  2x4  SHALL carry the packed write strobes.
REQ-010 req_ready  output  2  SHALL be a one-cycle accept pulse per requester.
REQ-011 rsp_valid  output  2  SHALL be a one-cycle completion pulse per requester.
REQ-012 rsp_rdata  output  32  SHALL hold read data, valid with rsp_valid.
REQ-013 rsp_err  output  1  SHALL hold the error status, valid with rsp_valid.
REQ-014 tim_psel, tim_penable, tim_pwrite  output  1 each  SHALL be the APB master controls toward the timer.
REQ-015 tim_paddr, tim_pwdata, tim_pstrb  output  ADDR_W/32/4  SHALL be the APB master address and data fields.
REQ-016 tim_prdata, tim_pready, tim_pslverr  input  32/1/1  SHALL be the APB completer response.

Function
REQ-017 FSM SHALL have the states IDLE, SETUP, ACCESS and RESP.
REQ-018 IDLE: if any req_valid is set, the block SHALL grant one requester, pulse its req_ready, capture its write/addr/wdata/strb, and move to SETUP.
REQ-019 Arbitration SHALL be 2-way round robin: with both valid, the requester not granted last SHALL win; after reset requester 0 SHALL win the first tie.
REQ-020 SETUP: psel=1 and penable=0 with the captured fields; the FSM SHALL move to ACCESS next cycle.
REQ-021 ACCESS: psel=1 and penable=1; the FSM SHALL hold until tim_pready=1.
REQ-022 With tim_pready=1, the block SHALL capture tim_prdata (reads only, 0 for writes) and tim_pslverr, then move to RESP.
REQ-023 RESP: the FSM SHALL pulse rsp_valid[grant] for exactly one cycle with the captured rsp_rdata/rsp_err, drop psel/penable, then return to IDLE.
REQ-024 Throughput SHALL be one transfer per 4 + W cycles, where W is the number of ACCESS wait cycles; a requester held valid in RESP SHALL NOT be accepted until IDLE.
REQ-025 The APB output fields SHALL stay stable from SETUP through the last ACCESS cycle; new req_* changes during that time SHALL be ignored.
REQ-026 A requester SHALL hold req_valid until req_ready; deasserting earlier SHALL leave no state change.
REQ-027 tim_pslverr=1 SHALL be forwarded as rsp_err=1; rsp_rdata SHALL then be 0.

Reset
REQ-028 When sys_rst=1 at a clock edge, the FSM SHALL go to IDLE and the last-grant pointer SHALL point to requester 1 (so requester 0 wins the first tie).
REQ-029 Under reset, all outputs SHALL be 0: req_ready, rsp_valid, rsp_rdata, rsp_err, psel, penable, pwrite, paddr, pwdata, pstrb.
REQ-030 Reset mid-transfer SHALL abort the transfer with no rsp_valid; psel and penable SHALL be 0 from the next cycle.

Configuration
REQ-031 With TIM_ARB_TIMEOUT_EN defined, a counter SHALL count ACCESS cycles; if it reaches TIMEOUT_CYC without tim_pready, the FSM SHALL go to RESP with rsp_err=1 and rsp_rdata=0.
REQ-032 The counter SHALL clear on entry to SETUP.
REQ-033 Without TIM_ARB_TIMEOUT_EN, the counter SHALL be absent and ACCESS SHALL wait indefinitely.

Structure
REQ-034 Package tim_arb_pkg SHALL hold the FSM state typedef, the NUM_REQ=2 constant and the default TIMEOUT_CYC.
REQ-035 Sub-module tim_rr_arb SHALL implement the 2-way round-robin grant: inputs are the valid vector, the pointer and an update strobe; the output is the one-hot grant.

Verification
REQ-036 Single write: r0 write addr 0x00C, data 0x0000_0064, strb 0xF; slave with 1 wait state -> ready0 in cycle 0, SETUP in cycle 1, ACCESS in cycles 2-3, rsp_valid0 in cycle 4, rsp_err=0.
REQ-037 Tie: r0 and r1 both valid at reset release -> r0 served first, then r1, then r0 again when both are held valid.
REQ-038 Read: r1 read addr 0x004 while the slave returns 0x1234_5678 -> rsp_valid1 with rsp_rdata=0x1234_5678.
REQ-039 Error: r0 access to addr 0x020 with pslverr=1 -> rsp_err=1 and rsp_rdata=0.
REQ-040 Timeout: with TIM_ARB_TIMEOUT_EN and TIMEOUT_CYC=16, pready held at 0 -> rsp_err=1 after 16 ACCESS cycles; reset in ACCESS -> psel=0 next cycle and no rsp_valid.
